// File: rtl/kasumi_round_sequencer.sv
// Drives one shared KASUMI round unit through 8 Feistel rounds; result 8*(1+RF_LAT)+1 cycles after accept.
// One block in flight: in_ready only when idle, result held on out_data until out_ready.
module kasumi_round_sequencer #(
  parameter int RF_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy,
  output logic [31:0]  rf_x,
  output logic         rf_odd,
  output logic [15:0]  rf_kl1,
  output logic [15:0]  rf_kl2,
  output logic [15:0]  rf_ko1,
  output logic [15:0]  rf_ko2,
  output logic [15:0]  rf_ko3,
  output logic [15:0]  rf_ki1,
  output logic [15:0]  rf_ki2,
  output logic [15:0]  rf_ki3,
  input  logic [31:0]  rf_y
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] WCNT_INIT = 2'(RF_LAT - 1);

  state_t      state_q, state_d;
  logic [31:0] l_q, r_q;
  logic [15:0] k_q [8];
  logic [3:0]  round_q;
  logic [1:0]  wcnt_q;
  logic        accept;
  logic        step;
  logic [2:0]  base;
  logic [15:0] k_i, k_i1, k_i5, k_i6;

  function automatic logic [15:0] kc(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'h0123;
      3'd1:    c = 16'h4567;
      3'd2:    c = 16'h89AB;
      3'd3:    c = 16'hCDEF;
      3'd4:    c = 16'hFEDC;
      3'd5:    c = 16'hBA98;
      3'd6:    c = 16'h7654;
      default: c = 16'h3210;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (wcnt_q == 2'd0) begin
          step    = 1'b1;
          state_d = (round_q == 4'd8) ? DONE : ISSUE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // L/R swap happens in the same edge that captures the round-unit result
  always_ff @(posedge clk) begin
    if (rst) begin
      l_q     <= 32'h0;
      r_q     <= 32'h0;
      round_q <= 4'd1;
      wcnt_q  <= 2'd0;
      for (int j = 0; j < 8; j++) k_q[j] <= 16'h0;
    end else begin
      if (accept) begin
        l_q     <= in_data[63:32];
        r_q     <= in_data[31:0];
        round_q <= 4'd1;
        for (int j = 0; j < 8; j++) k_q[j] <= in_key[127-16*j -: 16];
      end
      if (state_q == ISSUE) begin
        wcnt_q <= WCNT_INIT;
      end else if (state_q == WAIT && wcnt_q != 2'd0) begin
        wcnt_q <= wcnt_q - 2'd1;
      end
      if (step) begin
        l_q <= r_q ^ rf_y;
        r_q <= l_q;
        if (round_q != 4'd8) round_q <= round_q + 4'd1;
      end
    end
  end

  // base is (round-1); 3-bit adds give the mod-8 wrap of the subkey indices
  assign base = round_q[2:0] - 3'd1;
  assign k_i  = k_q[base];
  assign k_i1 = k_q[base + 3'd1];
  assign k_i5 = k_q[base + 3'd5];
  assign k_i6 = k_q[base + 3'd6];

  assign rf_kl1 = {k_i[14:0], k_i[15]};
  assign rf_kl2 = k_q[base + 3'd2] ^ kc(base + 3'd2);
  assign rf_ko1 = {k_i1[10:0], k_i1[15:11]};
  assign rf_ko2 = {k_i5[7:0], k_i5[15:8]};
  assign rf_ko3 = {k_i6[2:0], k_i6[15:3]};
  assign rf_ki1 = k_q[base + 3'd4] ^ kc(base + 3'd4);
  assign rf_ki2 = k_q[base + 3'd3] ^ kc(base + 3'd3);
  assign rf_ki3 = k_q[base + 3'd7] ^ kc(base + 3'd7);

  assign rf_x     = l_q;
  assign rf_odd   = round_q[0];
  assign out_data = {l_q, r_q};

endmodule

// File: tb/tb_kasumi_round_sequencer.sv
// Directed bench for kasumi_round_sequencer with RF_LAT=1 and RF_LAT=4 instances and a stub round unit.
module tb_kasumi_round_sequencer;

  typedef struct packed {
    logic [15:0] kl1, kl2, ko1, ko2, ko3, ki1, ki2, ki3;
  } sk_t;

  typedef struct {
    logic [1:0]   mode;
    logic [63:0]  data;
    logic [127:0] key;
    logic [63:0]  exp;
  } vec_t;

  localparam logic [127:0] KEY1 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [127:0] KEY2 = 128'h2BD6_459F_82C5_B300_B3CA_64C3_AF1D_6E29;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy, rf_odd;
  logic [63:0]  in_data, out_data;
  logic [127:0] in_key;
  logic [31:0]  rf_x, rf_y;
  logic [15:0]  rf_kl1, rf_kl2, rf_ko1, rf_ko2, rf_ko3, rf_ki1, rf_ki2, rf_ki3;

  logic         in_valid4, in_ready4, out_valid4, out_ready4, busy4, rf_odd4;
  logic [63:0]  in_data4, out_data4;
  logic [127:0] in_key4;
  logic [31:0]  rf_x4, rf_y4;
  logic [15:0]  kl1_4, kl2_4, ko1_4, ko2_4, ko3_4, ki1_4, ki2_4, ki3_4;

  logic [1:0]   mode, mode4;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  kasumi_round_sequencer #(.RF_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .rf_x(rf_x), .rf_odd(rf_odd),
    .rf_kl1(rf_kl1), .rf_kl2(rf_kl2), .rf_ko1(rf_ko1), .rf_ko2(rf_ko2), .rf_ko3(rf_ko3),
    .rf_ki1(rf_ki1), .rf_ki2(rf_ki2), .rf_ki3(rf_ki3), .rf_y(rf_y)
  );

  kasumi_round_sequencer #(.RF_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_key(in_key4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .busy(busy4),
    .rf_x(rf_x4), .rf_odd(rf_odd4),
    .rf_kl1(kl1_4), .rf_kl2(kl2_4), .rf_ko1(ko1_4), .rf_ko2(ko2_4), .rf_ko3(ko3_4),
    .rf_ki1(ki1_4), .rf_ki2(ki2_4), .rf_ki3(ki3_4), .rf_y(rf_y4)
  );

  // Stub round unit: 0 = zero, 1 = identity, 2 = keyed mix using every subkey
  function automatic logic [31:0] stub_f(input logic [1:0] m, input logic [31:0] x,
                                         input logic odd, input sk_t s);
    logic [31:0] t;
    case (m)
      2'd0: t = 32'h0;
      2'd1: t = x;
      default: begin
        t = odd ? (x ^ {s.kl1, s.kl2}) : x;
        t = {t[26:0], t[31:27]} + ({s.ko1, s.ki1} ^ {s.ko2, s.ki2});
        t = t ^ {s.ko3, s.ki3};
        if (!odd) t = t + {s.kl2, s.kl1};
      end
    endcase
    return t;
  endfunction

  sk_t rf_sk, rf_sk4;
  assign rf_sk  = {rf_kl1, rf_kl2, rf_ko1, rf_ko2, rf_ko3, rf_ki1, rf_ki2, rf_ki3};
  assign rf_sk4 = {kl1_4, kl2_4, ko1_4, ko2_4, ko3_4, ki1_4, ki2_4, ki3_4};

  always @(posedge clk) rf_y <= stub_f(mode, rf_x, rf_odd, rf_sk);

  logic [31:0] p4 [4];
  always @(posedge clk) begin
    p4[0] <= stub_f(mode4, rf_x4, rf_odd4, rf_sk4);
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign rf_y4 = p4[3];

  function automatic logic [15:0] kk(input logic [127:0] key, input int j);
    int jj;
    jj = (j - 1) % 8;
    return key[127-16*jj -: 16];
  endfunction

  function automatic logic [15:0] kcon(input int j);
    logic [15:0] c;
    case ((j - 1) % 8)
      0: c = 16'h0123;  1: c = 16'h4567;  2: c = 16'h89AB;  3: c = 16'hCDEF;
      4: c = 16'hFEDC;  5: c = 16'hBA98;  6: c = 16'h7654;  default: c = 16'h3210;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] rot(input logic [15:0] v, input int n);
    logic [31:0] w;
    w = {v, v} << n;
    return w[31:16];
  endfunction

  function automatic sk_t sched(input logic [127:0] key, input int i);
    sk_t s;
    s.kl1 = rot(kk(key, i), 1);
    s.kl2 = kk(key, i + 2) ^ kcon(i + 2);
    s.ko1 = rot(kk(key, i + 1), 5);
    s.ko2 = rot(kk(key, i + 5), 8);
    s.ko3 = rot(kk(key, i + 6), 13);
    s.ki1 = kk(key, i + 4) ^ kcon(i + 4);
    s.ki2 = kk(key, i + 3) ^ kcon(i + 3);
    s.ki3 = kk(key, i + 7) ^ kcon(i + 7);
    return s;
  endfunction

  function automatic logic [63:0] golden(input logic [1:0] m, input logic [63:0] d,
                                         input logic [127:0] key);
    logic [31:0] l, r, nl;
    l = d[63:32];
    r = d[31:0];
    for (int i = 1; i <= 8; i++) begin
      nl = r ^ stub_f(m, l, (i % 2) == 1, sched(key, i));
      r  = l;
      l  = nl;
    end
    return {l, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first ISSUE cycle
  task automatic send(input logic [63:0] d, input logic [127:0] k);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", 64'(in_ready), 64'd1);
    in_data  = d;
    in_key   = k;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts negedges after accept until out_valid; lat enters as negedges already elapsed
  task automatic wait_out(inout int lat);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vt [6];
  int   lat;
  int   acc [3];
  int   nacc, nout, n, seen;
  logic [63:0]  bd [3];
  logic [127:0] bk [3];
  logic [63:0]  be [3];
  logic [31:0]  ml, mr, nl;
  sk_t          s;

  initial begin
    vt[0] = '{2'd0, 64'h0123456789ABCDEF, KEY1, 64'h0123456789ABCDEF};
    vt[1] = '{2'd1, 64'h0000000100000000, KEY2, 64'h0000000000000001};
    vt[2] = '{2'd1, 64'h123456789ABCDEF0, KEY1, 64'h9ABCDEF088888888};
    vt[3] = '{2'd0, 64'hDEADBEEFCAFEF00D, KEY2, 64'hDEADBEEFCAFEF00D};
    vt[4] = '{2'd2, 64'h0123456789ABCDEF, KEY1, 64'h0};
    vt[5] = '{2'd2, 64'hFFFFFFFF00000000, KEY2, 64'h0};
    vt[4].exp = golden(2'd2, vt[4].data, vt[4].key);
    vt[5].exp = golden(2'd2, vt[5].data, vt[5].key);

    rst = 1'b1;
    in_valid = 1'b0;  in_data = 64'h0;  in_key = 128'h0;  out_ready = 1'b1;
    in_valid4 = 1'b0; in_data4 = 64'h0; in_key4 = 128'h0; out_ready4 = 1'b1;
    mode = 2'd0;
    mode4 = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_rf_x", 64'(rf_x), 64'd0);
    chk("rst_rf_odd", 64'(rf_odd), 64'd1);
    chk("rst4_in_ready", 64'(in_ready4), 64'd1);
    chk("rst4_busy", 64'(busy4), 64'd0);

    // Subkeys at round 1 and round 8 ISSUE for K = 1..8
    send(64'h0123456789ABCDEF, KEY1);
    chk("r1_kl1", 64'(rf_kl1), 64'h0002);
    chk("r1_kl2", 64'(rf_kl2), 64'h89A8);
    chk("r1_ko1", 64'(rf_ko1), 64'h0040);
    chk("r1_ko2", 64'(rf_ko2), 64'h0600);
    chk("r1_ko3", 64'(rf_ko3), 64'hE000);
    chk("r1_ki1", 64'(rf_ki1), 64'hFED9);
    chk("r1_ki2", 64'(rf_ki2), 64'hCDEB);
    chk("r1_ki3", 64'(rf_ki3), 64'h3218);
    chk("r1_odd", 64'(rf_odd), 64'd1);
    repeat (14) @(negedge clk);
    chk("r8_kl1", 64'(rf_kl1), 64'h0010);
    chk("r8_kl2", 64'(rf_kl2), 64'h4565);
    chk("r8_ko1", 64'(rf_ko1), 64'h0020);
    chk("r8_ko2", 64'(rf_ko2), 64'h0500);
    chk("r8_ko3", 64'(rf_ko3), 64'hC000);
    chk("r8_ki1", 64'(rf_ki1), 64'hCDEB);
    chk("r8_ki2", 64'(rf_ki2), 64'h89A8);
    chk("r8_ki3", 64'(rf_ki3), 64'h7653);
    chk("r8_odd", 64'(rf_odd), 64'd0);
    lat = 15;
    wait_out(lat);
    chk("sk_latency", 64'(lat), 64'd17);
    chk("sk_out_data", out_data, 64'h0123456789ABCDEF);
    @(negedge clk);

    // Table: per-round rf_x against the reference recurrence, exact latency, result
    for (int v = 0; v < 6; v++) begin
      mode = vt[v].mode;
      ml = vt[v].data[63:32];
      mr = vt[v].data[31:0];
      send(vt[v].data, vt[v].key);
      for (int i = 1; i <= 8; i++) begin
        chk($sformatf("v%0d_r%0d_rf_x", v, i), 64'(rf_x), 64'(ml));
        chk($sformatf("v%0d_r%0d_odd", v, i), 64'(rf_odd), 64'((i % 2) == 1));
        s  = sched(vt[v].key, i);
        nl = mr ^ stub_f(vt[v].mode, ml, (i % 2) == 1, s);
        mr = ml;
        ml = nl;
        @(negedge clk);
        chk($sformatf("v%0d_r%0d_out_valid_low", v, i), 64'(out_valid), 64'd0);
        @(negedge clk);
      end
      chk($sformatf("v%0d_out_valid_at_17", v), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_out_data", v), out_data, vt[v].exp);
      chk($sformatf("v%0d_model", v), {ml, mr}, vt[v].exp);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready_after", v), 64'(in_ready), 64'd1);
    end

    // Backpressure in DONE with in_valid pulses that must be ignored
    mode = 2'd2;
    out_ready = 1'b0;
    send(vt[5].data, vt[5].key);
    lat = 1;
    wait_out(lat);
    chk("bp_latency", 64'(lat), 64'd17);
    for (int j = 0; j < 10; j++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_data", out_data, vt[5].exp);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      in_valid = (j % 2) == 0;
      in_data  = 64'hFFFF0000FFFF0000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_out_valid_last", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_after", 64'(in_ready), 64'd1);
    chk("bp_busy_after", 64'(busy), 64'd0);
    chk("bp_out_valid_after", 64'(out_valid), 64'd0);

    // Reset during round 4 WAIT
    send(vt[4].data, vt[4].key);
    repeat (7) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_busy_after", 64'(busy), 64'd0);
    chk("mid_out_data", out_data, 64'd0);
    chk("mid_rf_x", 64'(rf_x), 64'd0);
    chk("mid_rf_odd", 64'(rf_odd), 64'd1);
    seen = 0;
    for (int j = 0; j < 20; j++) begin
      if (out_valid || busy) seen++;
      @(negedge clk);
    end
    chk("mid_no_output", 64'(seen), 64'd0);
    send(vt[5].data, vt[5].key);
    lat = 1;
    wait_out(lat);
    chk("mid_next_latency", 64'(lat), 64'd17);
    chk("mid_next_data", out_data, vt[5].exp);
    @(negedge clk);

    // Back-to-back with in_valid and out_ready held high
    bd[0] = 64'h0011223344556677; bk[0] = KEY2;
    bd[1] = 64'h8899AABBCCDDEEFF; bk[1] = KEY1;
    bd[2] = 64'hA5A5A5A55A5A5A5A; bk[2] = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
    for (int b = 0; b < 3; b++) be[b] = golden(2'd2, bd[b], bk[b]);
    in_data = bd[0];
    in_key = bk[0];
    in_valid = 1'b1;
    nacc = 0; nout = 0; n = 0;
    while (nout < 3 && n < 200) begin
      if (out_valid) begin
        chk($sformatf("b2b_out%0d", nout), out_data, be[nout]);
        nout++;
      end
      if (in_ready && in_valid) begin
        acc[nacc] = cyc;
        nacc++;
      end else if (nacc < 3) begin
        in_data = bd[nacc];
        in_key  = bk[nacc];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("b2b_outputs", 64'(nout), 64'd3);
    chk("b2b_accepts", 64'(nacc), 64'd3);
    if (nacc == 3) begin
      chk("b2b_spacing01", 64'(acc[1] - acc[0]), 64'd18);
      chk("b2b_spacing12", 64'(acc[2] - acc[1]), 64'd18);
    end
    @(negedge clk);

    // RF_LAT=4 instance: zero stub then keyed stub
    for (int r = 0; r < 2; r++) begin
      mode4 = (r == 0) ? 2'd0 : 2'd2;
      chk($sformatf("l4_%0d_in_ready", r), 64'(in_ready4), 64'd1);
      in_data4  = vt[4 + r].data;
      in_key4   = vt[4 + r].key;
      in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      lat = 1;
      while (!out_valid4 && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("l4_%0d_latency", r), 64'(lat), 64'd41);
      chk($sformatf("l4_%0d_out_data", r), out_data4,
          (r == 0) ? vt[4].data : golden(2'd2, vt[5].data, vt[5].key));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
